// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo_flags block: pointer/level width
// functions and the parameter-legality rules used by the top level.
package sync_fifo_pkg;

   localparam int MIN_DATA_W = 1;
   localparam int MIN_DEPTH  = 2;

   // Address width of the storage array.
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Occupancy counter width: one bit wider than the pointers so DEPTH fits.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v >= MIN_DEPTH) && ((v & (v - 1)) == 0);
   endfunction

   // Legal configuration: power-of-two depth, thresholds inside their ranges.
   function automatic bit cfg_legal(input int data_w, input int depth,
                                    input int af_thresh, input int ae_thresh);
      return (data_w >= MIN_DATA_W) && is_pow2(depth) &&
             (af_thresh >= 1) && (af_thresh <= depth) &&
             (ae_thresh >= 0) && (ae_thresh <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port storage: one synchronous write port, one read port.
// Read port is registered (reset to 0) in standard mode and purely
// combinational when SYNC_FIFO_FWFT_EN is defined. Contents are not reset.
module fifo_ram_2p
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic [ptr_w(DEPTH)-1:0]    waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       re,
   input  logic [ptr_w(DEPTH)-1:0]    raddr,
   output logic [DATA_W-1:0]          rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write port: store the word on an accepted write.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is always visible; the pop itself is handled by the pointers.
   assign rdata = mem_q[raddr];

   logic unused_rd;
   assign unused_rd = &{1'b0, re, rst_n};
`else
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // Capture the addressed word on a read, otherwise hold the last value.
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
   end

   // Read data register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact occupancy, almost-full/almost-empty flags
// and sticky overflow/underflow errors. Define SYNC_FIFO_FWFT_EN for
// first-word fall-through reads (rd_en becomes a pop acknowledge).
//
// Handshake: wr_en/rd_en are requests. A write transfers only when
// wr_en & ~full, a read only when rd_en & ~empty; a rejected request has
// no effect on storage or pointers and instead sets the matching sticky
// error flag. In standard mode rd_valid marks the cycle after an accepted
// read; in FWFT mode rd_valid = ~empty and rd_data is the head word.
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      rd_en,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      rd_valid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [lvl_w(DEPTH)-1:0]   level,
   input  logic                      clr_err,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int PW = ptr_w(DEPTH);
   localparam int LW = lvl_w(DEPTH);
   localparam bit CFG_OK = cfg_legal(DATA_W, DEPTH, AF_THRESH, AE_THRESH);

   if (!CFG_OK) begin : g_bad_cfg
      $error("sync_fifo_flags: illegal DEPTH or threshold parameters");
   end

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          wr_acc, rd_acc;

   // Flags decode from the registered level only.
   assign full         = (level_q == LW'(DEPTH));
   assign empty        = (level_q == '0);
   assign almost_full  = (level_q >= LW'(AF_THRESH));
   assign almost_empty = (level_q <= LW'(AE_THRESH));
   assign level        = level_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   // Next pointers, level and sticky errors; a new error beats clr_err.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (wr_acc) wptr_d = wptr_q + PW'(1);
      if (rd_acc) rptr_d = rptr_q + PW'(1);
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (clr_err) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (wr_en & full)  ovf_d = 1'b1;
      if (rd_en & empty) unf_d = 1'b1;
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rd_valid = ~empty;
`else
   logic rd_valid_q, rd_valid_d;

   // rd_valid follows an accepted read by one cycle.
   always_comb begin
      rd_valid_d = rd_acc;
   end

   // rd_valid register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_valid_q <= 1'b0;
      else        rd_valid_q <= rd_valid_d;
   end

   assign rd_valid = rd_valid_q;
`endif

   fifo_ram_2p #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wptr_q),
      .wdata (wr_data),
      .re    (rd_acc),
      .raddr (rptr_q),
      .rdata (rd_data)
   );

endmodule
